// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: instruction encodings, FSM states and IF/ID latch layout shared by fetch and decode
package if_fetch_unit_pkg;
    localparam int ADDR_W = 8;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] HALT_INSTR = 32'h0010_0073;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef enum logic {RUN = 1'b0, HALT = 1'b1} fetch_state_t;
    typedef struct packed {
        addr_t pc;
        addr_t pc_plus4;
        logic [31:0] instr;
        logic valid;
    } if_id_t;
    function automatic addr_t pc_inc(input addr_t a);
        return a + addr_t'(4);
    endfunction
    function automatic addr_t word_align(input addr_t a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/if_fetch_unit_if_id_reg.sv
// if_id_reg: IF/ID pipeline latch with hold and squash, resets to a bubble
module if_id_reg
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = if_fetch_unit_pkg::NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   hold,
    input  logic   squash,
    input  if_id_t d,
    output if_id_t q
);
    localparam if_id_t BUBBLE = '{pc: '0, pc_plus4: '0, instr: NOP_INSTR, valid: 1'b0};
    // reset and squash both force a bubble; squash wins over hold
    always_ff @(posedge clk) begin
        if (rst || squash) q <= BUBBLE;
        else if (!hold) q <= d;
    end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC, next-PC selection, RUN/HALT control and IF/ID latch of the fetch stage
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter addr_t       RESET_PC   = 8'h00,
    parameter logic [31:0] NOP_INSTR  = if_fetch_unit_pkg::NOP_INSTR,
    parameter logic [31:0] HALT_INSTR = if_fetch_unit_pkg::HALT_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [7:0]  redirect_addr,
    input  logic [31:0] instruction,
    output logic [7:0]  curr_addr,
    output logic [7:0]  if_id_pc,
    output logic [7:0]  if_id_pc_plus4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        halted
);
    localparam if_id_t BUBBLE = '{pc: '0, pc_plus4: '0, instr: NOP_INSTR, valid: 1'b0};
    fetch_state_t state, state_next;
    addr_t pc, pc_next;
    if_id_t if_id_d, if_id_q;
    logic is_halt_word;
    assign is_halt_word = instruction == HALT_INSTR;
    // PC and FSM state registers
    always_ff @(posedge clk) begin
        state <= rst ? RUN : state_next;
        pc <= rst ? RESET_PC : pc_next;
    end
    // redirect leaves any state; an unstalled EBREAK fetch enters HALT
    always_comb begin
        state_next = redirect ? RUN : stall ? state : (state == RUN && is_halt_word) ? HALT : state;
    end
    // PC freezes on stall, in HALT, and on the EBREAK address itself
    always_comb begin
        pc_next = redirect ? word_align(redirect_addr) :
                  (stall || state == HALT || is_halt_word) ? pc : pc_inc(pc);
    end
    // RUN latches the fetched word; HALT feeds bubbles
    always_comb begin
        if_id_d = state == RUN ? '{pc: pc, pc_plus4: pc_inc(pc), instr: instruction, valid: 1'b1} : BUBBLE;
        halted = state == HALT;
    end
    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk(clk),
        .rst(rst),
        .hold(stall && !redirect),
        .squash(redirect),
        .d(if_id_d),
        .q(if_id_q)
    );
    assign curr_addr = pc;
    assign if_id_pc = if_id_q.pc;
    assign if_id_pc_plus4 = if_id_q.pc_plus4;
    assign if_id_instr = if_id_q.instr;
    assign if_id_valid = if_id_q.valid;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: scoreboard bench for the fetch unit against a little-endian byte memory
module tb_if_fetch_unit;
    typedef struct packed {
        logic [7:0]  ca;
        logic [7:0]  pc;
        logic [7:0]  pc4;
        logic [31:0] ins;
        logic        v;
        logic        h;
    } obs_t;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] EBRK = 32'h0010_0073;
    logic clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect = 1'b0;
    logic [7:0] redirect_addr = 8'h00;
    logic [7:0] mem [256];
    logic [7:0] ca0, pc0, pc40, ca1, pc1, pc41;
    logic [31:0] ins0, ins1, iid0, iid1;
    logic v0, v1, h0, h1;
    obs_t sb[$];
    obs_t got, ex;
    int vecs = 0, errs = 0;

    always #5 clk = ~clk;

    assign ins0 = {mem[ca0 + 8'd3], mem[ca0 + 8'd2], mem[ca0 + 8'd1], mem[ca0]};
    assign ins1 = {mem[ca1 + 8'd3], mem[ca1 + 8'd2], mem[ca1 + 8'd1], mem[ca1]};

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_addr(redirect_addr),
        .instruction(ins0), .curr_addr(ca0), .if_id_pc(pc0), .if_id_pc_plus4(pc40),
        .if_id_instr(iid0), .if_id_valid(v0), .halted(h0)
    );
    if_fetch_unit #(.RESET_PC(8'hF8)) dut_f8 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_addr(redirect_addr),
        .instruction(ins1), .curr_addr(ca1), .if_id_pc(pc1), .if_id_pc_plus4(pc41),
        .if_id_instr(iid1), .if_id_valid(v1), .halted(h1)
    );

    function automatic logic [31:0] word(input logic [7:0] a);
        return {a, 8'hA5, ~a, 8'h3C};
    endfunction

    function automatic obs_t obs(input bit sel);
        return sel ? '{ca: ca1, pc: pc1, pc4: pc41, ins: iid1, v: v1, h: h1}
                   : '{ca: ca0, pc: pc0, pc4: pc40, ins: iid0, v: v0, h: h0};
    endfunction

    function automatic obs_t e(input logic [7:0] ca, pc, pc4, input logic [31:0] ins, input logic v, h);
        return '{ca: ca, pc: pc, pc4: pc4, ins: ins, v: v, h: h};
    endfunction

    task automatic set_word(input logic [7:0] a, input logic [31:0] w);
        mem[a] = w[7:0];
        mem[a + 8'd1] = w[15:8];
        mem[a + 8'd2] = w[23:16];
        mem[a + 8'd3] = w[31:24];
    endtask

    task automatic step(input logic s, r, input logic [7:0] ra, input logic rs);
        rst = rs;
        stall = s;
        redirect = r;
        redirect_addr = ra;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 1);
    endtask

    task automatic test_reset();
        sb.push_back(e(8'h00, 8'h00, 8'h00, NOP, 0, 0));
        sb.push_back(e(8'h00, 8'h00, 8'h00, NOP, 0, 0));
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 8'h00, 1);
            got = obs(0);
            ex = sb.pop_front();
            vecs++;
            if (got !== ex) begin
                errs++;
                $display("FAIL reset step %0d: got %h expected %h", i, got, ex);
            end
        end
    endtask

    task automatic test_fetch();
        do_reset();
        for (int i = 0; i < 4; i++)
            sb.push_back(e(8'(4 * i + 4), 8'(4 * i), 8'(4 * i + 4), word(8'(4 * i)), 1, 0));
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 8'h00, 0);
            got = obs(0);
            ex = sb.pop_front();
            vecs++;
            if (got !== ex) begin
                errs++;
                $display("FAIL fetch step %0d: got %h expected %h", i, got, ex);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        sb.push_back(e(8'h04, 8'h00, 8'h04, word(8'h00), 1, 0));
        sb.push_back(e(8'h08, 8'h04, 8'h08, word(8'h04), 1, 0));
        sb.push_back(e(8'h08, 8'h04, 8'h08, word(8'h04), 1, 0));
        sb.push_back(e(8'h08, 8'h04, 8'h08, word(8'h04), 1, 0));
        sb.push_back(e(8'h0C, 8'h08, 8'h0C, word(8'h08), 1, 0));
        sb.push_back(e(8'h10, 8'h0C, 8'h10, word(8'h0C), 1, 0));
        for (int i = 0; i < 6; i++) begin
            step(i == 2 || i == 3, 0, 8'h00, 0);
            got = obs(0);
            ex = sb.pop_front();
            vecs++;
            if (got !== ex) begin
                errs++;
                $display("FAIL stall step %0d: got %h expected %h", i, got, ex);
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        sb.push_back(e(8'h04, 8'h00, 8'h04, word(8'h00), 1, 0));
        sb.push_back(e(8'h40, 8'h00, 8'h00, NOP, 0, 0));
        sb.push_back(e(8'h44, 8'h40, 8'h44, word(8'h40), 1, 0));
        for (int i = 0; i < 3; i++) begin
            step(i == 1, i == 1, 8'h43, 0);
            got = obs(0);
            ex = sb.pop_front();
            vecs++;
            if (got !== ex) begin
                errs++;
                $display("FAIL redirect step %0d: got %h expected %h", i, got, ex);
            end
        end
    endtask

    task automatic test_back_to_back();
        sb.push_back(e(8'h80, 8'h00, 8'h00, NOP, 0, 0));
        sb.push_back(e(8'h10, 8'h00, 8'h00, NOP, 0, 0));
        sb.push_back(e(8'h14, 8'h10, 8'h14, word(8'h10), 1, 0));
        for (int i = 0; i < 3; i++) begin
            step(0, i < 2, i == 0 ? 8'h81 : 8'h12, 0);
            got = obs(0);
            ex = sb.pop_front();
            vecs++;
            if (got !== ex) begin
                errs++;
                $display("FAIL back_to_back step %0d: got %h expected %h", i, got, ex);
            end
        end
    endtask

    task automatic test_wrap();
        sb.push_back(e(8'hF8, 8'h00, 8'h00, NOP, 0, 0));
        sb.push_back(e(8'hFC, 8'hF8, 8'hFC, word(8'hF8), 1, 0));
        sb.push_back(e(8'h00, 8'hFC, 8'h00, word(8'hFC), 1, 0));
        sb.push_back(e(8'h04, 8'h00, 8'h04, word(8'h00), 1, 0));
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 8'h00, i == 0);
            got = obs(1);
            ex = sb.pop_front();
            vecs++;
            if (got !== ex) begin
                errs++;
                $display("FAIL wrap step %0d: got %h expected %h", i, got, ex);
            end
        end
    endtask

    task automatic test_halt();
        set_word(8'h08, EBRK);
        do_reset();
        sb.push_back(e(8'h04, 8'h00, 8'h04, word(8'h00), 1, 0));
        sb.push_back(e(8'h08, 8'h04, 8'h08, word(8'h04), 1, 0));
        sb.push_back(e(8'h08, 8'h08, 8'h0C, EBRK, 1, 1));
        sb.push_back(e(8'h08, 8'h08, 8'h0C, EBRK, 1, 1));
        sb.push_back(e(8'h08, 8'h00, 8'h00, NOP, 0, 1));
        sb.push_back(e(8'h00, 8'h00, 8'h00, NOP, 0, 0));
        sb.push_back(e(8'h04, 8'h00, 8'h04, word(8'h00), 1, 0));
        sb.push_back(e(8'h08, 8'h04, 8'h08, word(8'h04), 1, 0));
        sb.push_back(e(8'h08, 8'h08, 8'h0C, EBRK, 1, 1));
        sb.push_back(e(8'h00, 8'h00, 8'h00, NOP, 0, 0));
        for (int i = 0; i < 10; i++) begin
            step(i == 3, i == 5, 8'h00, i == 9);
            got = obs(0);
            ex = sb.pop_front();
            vecs++;
            if (got !== ex) begin
                errs++;
                $display("FAIL halt step %0d: got %h expected %h", i, got, ex);
            end
        end
        set_word(8'h08, word(8'h08));
    endtask

    initial begin
        for (int a = 0; a < 256; a += 4)
            set_word(8'(a), word(8'(a)));
        test_reset();
        test_fetch();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
